// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall-vector
// bit positions, stall encodings, FSM state encoding and common constants.
package pipe_ctrl_pkg;

  // Bit positions inside the 6-bit stall vector {wb,mem,ex,id,if,pc}
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A stall from stage X freezes X and every stage upstream of it
  localparam logic [5:0] StallNone    = 6'b000000;
  localparam logic [5:0] StallFromIf  = 6'b000011;
  localparam logic [5:0] StallFromId  = 6'b000111;
  localparam logic [5:0] StallFromEx  = 6'b001111;
  localparam logic [5:0] StallFromMem = 6'b011111;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline stall requests, MDU/exception events and the resulting
// stall/flush controls. The pipeline drives the master side, the
// controller sits on the slave side.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        mdu_start;
  logic        exc_req;
  logic [31:0] exc_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        mdu_busy;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem, mdu_start, exc_req, exc_target,
    input  stall, flush, flush_pc, mdu_busy
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem, mdu_start, exc_req, exc_target,
    output stall, flush, flush_pc, mdu_busy
  );
endinterface

// File: rtl/pipe_ctrl_mdu_timer.sv
// Loadable down-counter that times MDU occupancy of EX. done flags the last
// wait cycle (count == 1) so the controller can return to RUN on that edge.
module mdu_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int               CNT_W    = 6,
  parameter logic [CNT_W-1:0] LOAD_VAL = CNT_W'(31)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic done
);

  logic [CNT_W-1:0] cnt_reg;

  // Counter: clear beats load, load beats decrement; never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional feature macro: PIPE_CTRL_PERF_EN adds a saturating 32-bit count
// of cycles in which the PC is held (perf_stall_cnt).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt
`endif
);

  state_t      state_reg, state_next;
  logic [31:0] flush_pc_reg;
  logic        timer_load, timer_clear, mdu_done;
  logic [5:0]  stall_vec;

  // EX is held in cycle N by mdu_start itself, then MDU_LAT-1 more cycles
  // in MDU_WAIT; the timer therefore starts at MDU_LAT-1 and ends at 1.
  mdu_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (CNT_W'(MDU_LAT - 1))
  ) u_mdu_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .clear (timer_clear),
    .run   (state_reg == ST_MDU_WAIT),
    .done  (mdu_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Redirect address: captured with every exception, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      flush_pc_reg <= ZeroWord;
    end else if (bus.exc_req) begin
      flush_pc_reg <= bus.exc_target;
    end
  end

  // Next state and timer control; an exception overrides everything
  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    if (bus.exc_req) begin
      state_next  = ST_FLUSH;
      timer_clear = 1'b1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.mdu_start) begin
            state_next = ST_MDU_WAIT;
            timer_load = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done) begin
            state_next = ST_RUN;
          end
        end
        ST_FLUSH: begin
          state_next = ST_RUN;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // Stall priority encoder: flush clears everything, MEM beats EX beats ID beats IF
  always_comb begin
    stall_vec = StallNone;
    if (state_reg == ST_FLUSH) begin
      stall_vec = StallNone;
    end else if (bus.stallreq_mem) begin
      stall_vec = StallFromMem;
    end else if ((bus.mdu_start && (state_reg == ST_RUN)) || (state_reg == ST_MDU_WAIT)) begin
      stall_vec = StallFromEx;
    end else if (bus.stallreq_id) begin
      stall_vec = StallFromId;
    end else if (bus.stallreq_if) begin
      stall_vec = StallFromIf;
    end
  end

  assign bus.stall    = stall_vec;
  assign bus.flush    = (state_reg == ST_FLUSH);
  assign bus.flush_pc = flush_pc_reg;
  assign bus.mdu_busy = (state_reg == ST_MDU_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cnt_reg;

  // PC-hold cycle counter, saturating at all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      perf_cnt_reg <= ZeroWord;
    end else if (stall_vec[STALL_PC] && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_reg;
`endif

  // A new MDU op may only be issued while no other op or flush is in progress
  mdu_start_only_in_run: assert property (
    @(posedge clk) disable iff (rst) bus.mdu_start |-> (state_reg == ST_RUN)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: a table of stall-priority
// vectors plus hand-written MDU, exception and async-reset sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MDU_LAT = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  pipe_ctrl #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sif;
    logic       sid;
    logic       smem;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic clear_inputs();
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.mdu_start    = 1'b0;
    bus.exc_req      = 1'b0;
    bus.exc_target   = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full MDU hold with optional stallreq_mem window (wait cycles mem_lo..mem_hi)
  task automatic mdu_run(input string tag, input int mem_lo, input int mem_hi);
    bus.mdu_start = 1'b1;
    @(negedge clk);
    check($sformatf("%s_start_stall", tag), 32'(bus.stall), 32'(6'b001111));
    check($sformatf("%s_start_busy", tag), 32'(bus.mdu_busy), 32'd0);
    next_cycle();
    bus.mdu_start = 1'b0;
    for (int i = 1; i < MDU_LAT; i++) begin
      bus.stallreq_mem = (i >= mem_lo) && (i <= mem_hi);
      @(negedge clk);
      check($sformatf("%s_wait%0d_stall", tag, i), 32'(bus.stall),
            bus.stallreq_mem ? 32'(6'b011111) : 32'(6'b001111));
      check($sformatf("%s_wait%0d_busy", tag, i), 32'(bus.mdu_busy), 32'd1);
      next_cycle();
    end
    bus.stallreq_mem = 1'b0;
    @(negedge clk);
    check($sformatf("%s_end_stall", tag), 32'(bus.stall), 32'(6'b000000));
    check($sformatf("%s_end_busy", tag), 32'(bus.mdu_busy), 32'd0);
    next_cycle();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'b000111};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'b000111};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 6'b011111};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 6'b011111};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 6'b011111};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 6'b011111};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_flush", 32'(bus.flush), 32'd0);
    check("reset_flush_pc", bus.flush_pc, 32'h0);
    check("reset_busy", 32'(bus.mdu_busy), 32'd0);
    next_cycle();

    // Stall priority table
    for (int i = 0; i < 8; i++) begin
      bus.stallreq_if  = vecs[i].sif;
      bus.stallreq_id  = vecs[i].sid;
      bus.stallreq_mem = vecs[i].smem;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'd0);
      next_cycle();
    end
    clear_inputs();

    // Load-use stall for two cycles, second one with IF also requesting
    bus.stallreq_id = 1'b1;
    @(negedge clk);
    check("id_c1_stall", 32'(bus.stall), 32'(6'b000111));
    next_cycle();
    bus.stallreq_if = 1'b1;
    @(negedge clk);
    check("id_c2_stall", 32'(bus.stall), 32'(6'b000111));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("id_after_stall", 32'(bus.stall), 32'(6'b000000));
    next_cycle();

    // Plain MDU hold, then one with a MEM stall in the middle of the wait
    mdu_run("mdu", 0, -1);
    mdu_run("mdumem", 5, 7);

    // Exception aborting an MDU wait
    bus.mdu_start = 1'b1;
    next_cycle();
    bus.mdu_start = 1'b0;
    for (int i = 1; i < 20; i++) next_cycle();
    bus.exc_req    = 1'b1;
    bus.exc_target = 32'hBFC0_0380;
    @(negedge clk);
    check("exc_req_cycle_busy", 32'(bus.mdu_busy), 32'd1);
    check("exc_req_cycle_flush", 32'(bus.flush), 32'd0);
    next_cycle();
    // Second exception in the flush cycle, with a MEM stall that flush must mask
    bus.exc_target   = 32'h8000_0180;
    bus.stallreq_mem = 1'b1;
    @(negedge clk);
    check("flush1_flush", 32'(bus.flush), 32'd1);
    check("flush1_pc", bus.flush_pc, 32'hBFC0_0380);
    check("flush1_stall", 32'(bus.stall), 32'(6'b000000));
    check("flush1_busy", 32'(bus.mdu_busy), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("flush2_flush", 32'(bus.flush), 32'd1);
    check("flush2_pc", bus.flush_pc, 32'h8000_0180);
    next_cycle();
    @(negedge clk);
    check("post_flush_flush", 32'(bus.flush), 32'd0);
    check("post_flush_pc_hold", bus.flush_pc, 32'h8000_0180);
    check("post_flush_stall", 32'(bus.stall), 32'(6'b000000));
    check("post_flush_busy", 32'(bus.mdu_busy), 32'd0);
    next_cycle();

    // Async reset in the middle of an MDU wait
    bus.mdu_start = 1'b1;
    next_cycle();
    bus.mdu_start = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.mdu_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.mdu_busy), 32'd0);
    check("async_rst_stall", 32'(bus.stall), 32'(6'b000000));
    check("async_rst_flush_pc", bus.flush_pc, 32'h0);
    check("async_rst_flush", 32'(bus.flush), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    mdu_run("mdu_after_rst", 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
